// File: rtl/riscv_defines.sv
// Shared definitions for the core interrupt path: privilege levels,
// the interrupt-controller handshake states and the default line count.
package riscv_defines;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } PrivLvl_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_DONE    = 2'd2
    } irq_state_t;

    localparam int IRQ_NUM_DEFAULT = 32;

endpackage

// File: rtl/riscv_irq_prio_controller_prio_enc.sv
// Lowest-index-wins priority encoder for the eligible interrupt vector.
module riscv_irq_prio_enc #(
    parameter  int NUM_IRQ  = 32,
    localparam int IRQ_ID_W = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]  elig,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |elig;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_prio_controller.sv
// Multi-line interrupt priority controller feeding the ID-stage controller
// through a req/ack/kill handshake. Edge lines latch rising edges; level
// lines are used directly. Lowest eligible index wins.
// Optional macro RISCV_IRQ_TAIL_CHAIN_EN: re-arbitrate straight out of
// IRQ_DONE, skipping the IDLE bubble when another line is already eligible.
module riscv_irq_prio_controller
    import riscv_defines::*;
#(
    parameter  int NUM_IRQ     = IRQ_NUM_DEFAULT,
    parameter  int PULP_SECURE = 0,
    localparam int IRQ_ID_W    = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  irq_mask_i,
    input  logic [NUM_IRQ-1:0]  irq_edge_i,
    input  logic [NUM_IRQ-1:0]  irq_sec_i,
    input  logic                m_IE_i,
    input  logic                u_IE_i,
    input  PrivLvl_t            current_priv_lvl_i,
    output logic                irq_req_ctrl_o,
    output logic [IRQ_ID_W-1:0] irq_id_ctrl_o,
    output logic                irq_sec_ctrl_o,
    input  logic                ctrl_ack_i,
    input  logic                ctrl_kill_i,
    output logic [NUM_IRQ-1:0]  irq_pending_o
);

    irq_state_t          state_q, state_d;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic                sec_q, sec_d;
    logic [NUM_IRQ-1:0]  irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0]  edge_pend_q, edge_pend_d;
    logic [NUM_IRQ-1:0]  pend, line_en, elig;
    logic [IRQ_ID_W-1:0] sel_id;
    logic                sel_valid, sel_sec, ack_take;

    // Global/privilege gating; with PULP_SECURE a secure line may interrupt U-mode
    // even when U-mode interrupts are disabled.
    always_comb begin
        line_en = {NUM_IRQ{m_IE_i}};
        if (PULP_SECURE != 0) begin
            line_en = '0;
            if (current_priv_lvl_i == PRIV_LVL_U) begin
                line_en = {NUM_IRQ{u_IE_i}} | irq_sec_i;
            end else if (current_priv_lvl_i == PRIV_LVL_M) begin
                line_en = {NUM_IRQ{m_IE_i}};
            end
        end
    end

    // Effective pending and eligible vectors; mask gates eligibility, never latching.
    always_comb begin
        pend = (irq_edge_i & edge_pend_q) | (~irq_edge_i & irq_i);
        elig = pend & irq_mask_i & line_en;
    end

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .elig  (elig),
        .valid (sel_valid),
        .id    (sel_id)
    );

    assign sel_sec = irq_sec_i[sel_id];

    // Handshake FSM: capture on entry to IRQ_PENDING and freeze until ack or kill.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        sec_d    = sec_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    id_d    = sel_id;
                    sec_d   = sel_sec;
                    state_d = IRQ_PENDING;
                end
            end
            IRQ_PENDING: begin
                if (ctrl_ack_i) begin
                    ack_take = 1'b1;
                    state_d  = IRQ_DONE;
                end else if (ctrl_kill_i) begin
                    state_d = IDLE;
                end
            end
            IRQ_DONE: begin
                sec_d   = 1'b0;
                state_d = IDLE;
`ifdef RISCV_IRQ_TAIL_CHAIN_EN
                if (sel_valid) begin
                    id_d    = sel_id;
                    sec_d   = sel_sec;
                    state_d = IRQ_PENDING;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Edge latching: the ack clears the taken line, a same-cycle rising edge re-sets it.
    always_comb begin
        irq_prev_d  = irq_i;
        edge_pend_d = edge_pend_q;
        if (ack_take && irq_edge_i[id_q]) begin
            edge_pend_d[id_q] = 1'b0;
        end
        edge_pend_d = edge_pend_d | (irq_i & ~irq_prev_q & irq_edge_i);
    end

    // State, capture and edge-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            sec_q       <= 1'b0;
            irq_prev_q  <= '0;
            edge_pend_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            sec_q       <= sec_d;
            irq_prev_q  <= irq_prev_d;
            edge_pend_q <= edge_pend_d;
        end
    end

    assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
    assign irq_id_ctrl_o  = id_q;
    assign irq_sec_ctrl_o = sec_q;
    assign irq_pending_o  = pend;

endmodule
